// File: rtl/pkg_proto_para.sv
// Frame constants, command codes and FSM encodings shared by the host
// command parser and the response packet transmitter.
package pkg_proto_para;

    localparam logic [7:0] FRAME_HEAD = 8'h3A;
    localparam logic [7:0] FRAME_TAIL = 8'h0A;

    localparam logic [15:0] CMD_NOP    = 16'h0000;
    localparam logic [15:0] CMD_STATUS = 16'h0001;
    localparam logic [15:0] CMD_DATA   = 16'h0002;
    localparam logic [15:0] CMD_ACK    = 16'h0003;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_CMDL,
        ST_CMDH,
        ST_PAY,
        ST_CHK,
        ST_TAIL,
        ST_DONE
    } pkt_state_e;

    // Two's complement of the running sum, so covered bytes plus CHK wrap to 0.
    function automatic logic [7:0] chk_of(input logic [7:0] sum);
        return 8'(~sum + 8'd1);
    endfunction

endpackage

// File: rtl/pkg_checksum_acc.sv
// 8-bit wrapping clear/add accumulator; o_chk is the value that brings the
// accumulated bytes back to zero mod 256.
module pkg_checksum_acc
    import pkg_proto_para::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic [7:0] o_chk
);

    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= 8'h00;
        end else if (i_clr) begin
            r_sum <= 8'h00;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_chk = chk_of(r_sum);

endmodule

// File: rtl/resp_pkg_tx.sv
// Response packet transmitter: frames cmd/len/payload with header, checksum
// and tail and pushes the bytes one per cycle into the FT232 TX FIFO.
module resp_pkg_tx
    import pkg_proto_para::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_start,
    input  logic [15:0]      tx_cmd,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             pay_valid,
    input  logic [7:0]       pay_data,
    output logic             pay_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_data,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);

    pkt_state_e       r_state;
    logic [1:0]       r_len_idx;
    logic [15:0]      r_cmd;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pay_cnt;
    logic             r_wr_en;
    logic [7:0]       r_data;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_pay_ready;
    logic             w_emit;
    logic             w_cover;
    logic [7:0]       w_byte;
    logic [7:0]       w_chk;
    logic [31:0]      w_len32;
    logic [LEN_W-1:0] w_pay_next;
    logic             w_accept;

    assign w_len32     = 32'(r_len);
    assign w_pay_next  = r_pay_cnt + LEN_W'(1);
    assign w_pay_ready = (r_state == ST_PAY) && !fifo_full;
    // A start in the tx_done cycle is dropped; the next packet begins one cycle later.
    assign w_accept    = (r_state == ST_IDLE) && tx_start && !r_done
                         && (tx_len <= LEN_W'(MAX_LEN));

    always_comb begin
        w_emit  = 1'b0;
        w_cover = 1'b0;
        w_byte  = 8'h00;
        case (r_state)
            ST_HDR: begin
                w_emit = !fifo_full;
                w_byte = FRAME_HEAD;
            end
            ST_LEN: begin
                w_emit  = !fifo_full;
                w_cover = 1'b1;
                case (r_len_idx)
                    2'd0: w_byte = w_len32[7:0];
                    2'd1: w_byte = w_len32[15:8];
                    2'd2: w_byte = w_len32[23:16];
                    2'd3: w_byte = w_len32[31:24];
                endcase
            end
            ST_CMDL: begin
                w_emit  = !fifo_full;
                w_cover = 1'b1;
                w_byte  = r_cmd[7:0];
            end
            ST_CMDH: begin
                w_emit  = !fifo_full;
                w_cover = 1'b1;
                w_byte  = r_cmd[15:8];
            end
            ST_PAY: begin
                w_emit  = w_pay_ready && pay_valid;
                w_cover = 1'b1;
                w_byte  = pay_data;
            end
            ST_CHK: begin
                w_emit = !fifo_full;
                w_byte = w_chk;
            end
            ST_TAIL: begin
                w_emit = !fifo_full;
                w_byte = FRAME_TAIL;
            end
            default: ;
        endcase
    end

    pkg_checksum_acc u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_add  (w_emit && w_cover),
        .i_byte (w_byte),
        .o_chk  (w_chk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_len_idx <= 2'd0;
            r_cmd     <= 16'h0000;
            r_len     <= '0;
            r_pay_cnt <= '0;
            r_wr_en   <= 1'b0;
            r_data    <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_emit;
            if (w_emit) begin
                r_data <= w_byte;
            end
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= tx_cmd;
                        r_len   <= tx_len;
                        r_busy  <= 1'b1;
                        r_state <= ST_HDR;
                    end else if (tx_start && !r_done) begin
                        r_err <= 1'b1;
                    end
                end
                ST_HDR: if (w_emit) begin
                    r_len_idx <= 2'd0;
                    r_state   <= ST_LEN;
                end
                ST_LEN: if (w_emit) begin
                    r_len_idx <= r_len_idx + 2'd1;
                    if (r_len_idx == 2'd3) begin
                        r_state <= ST_CMDL;
                    end
                end
                ST_CMDL: if (w_emit) begin
                    r_state <= ST_CMDH;
                end
                ST_CMDH: if (w_emit) begin
                    r_pay_cnt <= '0;
                    r_state   <= (r_len == '0) ? ST_CHK : ST_PAY;
                end
                ST_PAY: if (w_emit) begin
                    r_pay_cnt <= w_pay_next;
                    if (w_pay_next == r_len) begin
                        r_state <= ST_CHK;
                    end
                end
                ST_CHK: if (w_emit) begin
                    r_state <= ST_TAIL;
                end
                ST_TAIL: if (w_emit) begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pay_ready  = w_pay_ready;
    assign fifo_wr_en = r_wr_en;
    assign fifo_data  = r_data;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule
